// File: rtl/coproc_sequencer_if.sv
// Byte-stream and coprocessor signals of the command sequencer, grouped so the
// sequencer (slave) and its environment (master) share one bundle.
interface coproc_sequencer_if #(
    parameter int WIDTH_DIN  = 128,
    parameter int WIDTH_DOUT = 128
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic [7:0]            tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [WIDTH_DIN-1:0]  cp_din;
    logic                  cp_din_valid;
    logic                  cp_rst;
    logic [2:0]            cp_sel;
    logic [WIDTH_DOUT-1:0] cp_dout;
    logic                  busy;
    logic [7:0]            err_count;

    modport master (
        output rx_data, rx_valid, tx_ready, cp_dout,
        input  tx_data, tx_valid, cp_din, cp_din_valid, cp_rst, cp_sel, busy, err_count
    );

    modport slave (
        input  rx_data, rx_valid, tx_ready, cp_dout,
        output tx_data, tx_valid, cp_din, cp_din_valid, cp_rst, cp_sel, busy, err_count
    );
endinterface

// File: rtl/coproc_sequencer.sv
// Framed byte-command sequencer: assembles operands from RX, strobes them into the
// coprocessor, settles readback views and streams results out over TX.
module coproc_sequencer #(
    parameter int WIDTH_DIN      = 128,
    parameter int WIDTH_DOUT     = 128,
    parameter int GAP_CYCLES     = 256,
    parameter int SETTLE_CYCLES  = 128,
    parameter int RST_CYCLES     = 256,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input logic               clk,
    input logic               rst,
    coproc_sequencer_if.slave bus
);
    localparam int N_DIN   = WIDTH_DIN / 8;
    localparam int N_DOUT  = WIDTH_DOUT / 8;
    localparam int M1      = (GAP_CYCLES > SETTLE_CYCLES) ? GAP_CYCLES : SETTLE_CYCLES;
    localparam int M2      = (M1 > RST_CYCLES) ? M1 : RST_CYCLES;
    localparam int CNT_MAX = (M2 > TIMEOUT_CYCLES) ? M2 : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int N_MAX   = (N_DIN > N_DOUT) ? N_DIN : N_DOUT;
    localparam int IDX_W   = $clog2(N_MAX + 1);

    localparam logic [7:0] OP_WRITE = 8'h01;
    localparam logic [7:0] OP_READ  = 8'h02;
    localparam logic [7:0] OP_RESET = 8'h03;

    typedef enum logic [2:0] {
        IDLE, RX_PAYLOAD, ISSUE, GAP, SETTLE, TX, CP_RESET
    } state_t;

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      cnt_reg, cnt_next;
    logic [IDX_W-1:0]      idx_reg, idx_next;
    logic                  op_read_reg, op_read_next;
    logic [WIDTH_DIN-1:0]  asm_reg, asm_next;
    logic [WIDTH_DIN-1:0]  din_reg, din_next;
    logic [WIDTH_DOUT-1:0] shift_reg, shift_next;
    logic [2:0]            sel_reg, sel_next;
    logic [7:0]            err_reg, err_next;
    logic                  proto_err;
    logic                  busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            idx_reg     <= '0;
            op_read_reg <= 1'b0;
            asm_reg     <= '0;
            din_reg     <= '0;
            shift_reg   <= '0;
            sel_reg     <= 3'b100;
            err_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            idx_reg     <= idx_next;
            op_read_reg <= op_read_next;
            asm_reg     <= asm_next;
            din_reg     <= din_next;
            shift_reg   <= shift_next;
            sel_reg     <= sel_next;
            err_reg     <= err_next;
        end
    end

    // cnt_reg is shared: idle-byte timeout in RX_PAYLOAD, dwell length in GAP/SETTLE/CP_RESET.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        idx_next     = idx_reg;
        op_read_next = op_read_reg;
        asm_next     = asm_reg;
        din_next     = din_reg;
        shift_next   = shift_reg;
        sel_next     = sel_reg;
        proto_err    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.rx_valid) begin
                    cnt_next = '0;
                    idx_next = '0;
                    case (bus.rx_data)
                        OP_WRITE: begin state_next = RX_PAYLOAD; op_read_next = 1'b0; end
                        OP_READ:  begin state_next = RX_PAYLOAD; op_read_next = 1'b1; end
                        OP_RESET: state_next = CP_RESET;
                        default:  proto_err = 1'b1;
                    endcase
                end
            end
            RX_PAYLOAD: begin
                if (bus.rx_valid) begin
                    cnt_next = '0;
                    if (op_read_reg) begin
                        sel_next   = bus.rx_data[2:0];
                        state_next = SETTLE;
                    end else begin
                        asm_next = {bus.rx_data, asm_reg[WIDTH_DIN-1:8]};
                        idx_next = idx_reg + IDX_W'(1);
                        // Load the operand now so it is already stable during the strobe cycle.
                        if (idx_reg == IDX_W'(N_DIN - 1)) begin
                            din_next   = {bus.rx_data, asm_reg[WIDTH_DIN-1:8]};
                            state_next = ISSUE;
                        end
                    end
                end else if (cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    proto_err  = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ISSUE: begin
                cnt_next   = '0;
                state_next = GAP;
            end
            GAP: begin
                if (cnt_reg == CNT_W'(GAP_CYCLES - 1)) state_next = IDLE;
                else                                    cnt_next   = cnt_reg + CNT_W'(1);
            end
            SETTLE: begin
                if (cnt_reg == CNT_W'(SETTLE_CYCLES - 1)) begin
                    shift_next = bus.cp_dout;
                    idx_next   = '0;
                    state_next = TX;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            TX: begin
                if (bus.tx_ready) begin
                    shift_next = {8'h00, shift_reg[WIDTH_DOUT-1:8]};
                    idx_next   = idx_reg + IDX_W'(1);
                    if (idx_reg == IDX_W'(N_DOUT - 1)) state_next = IDLE;
                end
            end
            CP_RESET: begin
                if (cnt_reg == CNT_W'(RST_CYCLES - 1)) state_next = IDLE;
                else                                    cnt_next   = cnt_reg + CNT_W'(1);
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state_reg != IDLE) && (state_reg != RX_PAYLOAD);

    // Overrun and protocol error are OR-ed so a coincidence counts once.
    always_comb begin
        err_next = err_reg;
        if (((bus.rx_valid && busy) || proto_err) && (err_reg != 8'hFF))
            err_next = err_reg + 8'd1;
    end

    assign bus.busy         = busy;
    assign bus.tx_valid     = (state_reg == TX);
    assign bus.tx_data      = shift_reg[7:0];
    assign bus.cp_din       = din_reg;
    assign bus.cp_din_valid = (state_reg == ISSUE);
    assign bus.cp_rst       = (state_reg == CP_RESET);
    assign bus.cp_sel       = sel_reg;
    assign bus.err_count    = err_reg;
endmodule

// File: doc/coproc_sequencer.md
Name: coproc_sequencer

Overview:
Byte-stream command sequencer between the UART RX/TX byte interfaces and the dial coprocessor. Parses framed commands from RX bytes and assembles 16-byte operands. Issues single-cycle din_valid strobes to the coprocessor with an enforced inter-issue gap. Selects and settles readback views, then serialises the selected result back out over TX with a valid/ready handshake.

Parameters:
WIDTH_DIN, 128, coprocessor operand width; multiple of 8.
WIDTH_DOUT, 128, coprocessor result width; multiple of 8.
GAP_CYCLES, 256, minimum clk cycles after a din_valid strobe before the next command is accepted (covers slow-clock pulse extension).
SETTLE_CYCLES, 128, clk cycles between a cp_sel change and capture of cp_dout.
RST_CYCLES, 256, length of the cp_rst pulse for the RESET command.
TIMEOUT_CYCLES, 1000000, maximum idle clk cycles between payload bytes within one frame.

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rx_data  in  8  received byte
rx_valid  in  1  one-cycle strobe; rx_data is valid this cycle
tx_data  out  8  byte to transmit
tx_valid  out  1  tx_data valid; held until accepted
tx_ready  in  1  transmitter accepts the byte when tx_valid && tx_ready
cp_din  out  WIDTH_DIN  operand to coprocessor
cp_din_valid  out  1  one-cycle issue strobe
cp_rst  out  1  coprocessor reset
cp_sel  out  3  coprocessor readback select (control[2:0])
cp_dout  in  WIDTH_DOUT  coprocessor result
busy  out  1  high in every state except IDLE and RX_PAYLOAD
err_count  out  8  saturating error counter

Behaviour:
- Reset is synchronous and active-high on clk. All outputs go to 0 except cp_sel, which resets to 3'b100 (answer view). State goes to IDLE.
- Frame format: opcode byte, then payload.
  - 0x01 WRITE: 16 payload bytes (WIDTH_DIN/8), little-endian; the first byte becomes cp_din[7:0].
  - 0x02 READ: 1 payload byte; bits [2:0] are the select, bits [7:3] are ignored.
  - 0x03 RESET: no payload.
  - Any other opcode: byte is discarded, err_count increments, state stays IDLE.
- States: IDLE, RX_PAYLOAD, ISSUE, GAP, SETTLE, TX, CP_RESET.
- IDLE: on rx_valid, decode the opcode.
  - WRITE or READ: go to RX_PAYLOAD with byte index 0.
  - RESET: go to CP_RESET.
- RX_PAYLOAD:
  - Each rx_valid shifts the byte into the assembly register and increments the index.
  - The timeout counter reloads on every accepted byte. On expiry, the frame is abandoned, err_count increments, and state returns to IDLE; the partial operand is not issued and cp_din is unchanged.
  - WRITE: after the last byte, go to ISSUE.
  - READ: after the select byte, set cp_sel and go to SETTLE.
- ISSUE (1 cycle): cp_din loads the assembled word and cp_din_valid=1 in the same cycle. Next state is GAP.
  - cp_din_valid is high for exactly 1 cycle, on the cycle after the last payload byte's rx_valid.
  - cp_din holds its value until the next ISSUE.
- GAP: count GAP_CYCLES, then go to IDLE.
- SETTLE: count SETTLE_CYCLES. Then capture cp_dout into a shift register, zero the byte counter, and go to TX.
- TX: tx_valid=1 with tx_data = the current low byte.
  - On tx_valid && tx_ready, shift by 8 and increment the counter.
  - After WIDTH_DOUT/8 bytes are accepted, drop tx_valid and go to IDLE.
  - tx_data and tx_valid stay stable while tx_ready is low.
- CP_RESET: cp_rst=1 for exactly RST_CYCLES cycles, then cp_rst=0 and go to IDLE. cp_sel is unchanged.
- Overrun: rx_valid while busy=1 drops the byte and increments err_count. It does not affect state or counters.
- Simultaneous events:
  - Timeout expiry and rx_valid in the same cycle: the byte is accepted and the timeout does not fire.
  - An overrun and a protocol error in the same cycle count as +1 only.
- err_count saturates at 0xFF and is cleared only by rst.
- rst asserted mid-frame, mid-GAP or mid-TX aborts immediately: tx_valid=0 and cp_rst=0 the next cycle, and no partial din_valid is issued.

Test Plan:
- Reset: hold rst for 3 cycles -> all outputs 0, cp_sel=3'b100, busy=0, err_count=0.
- WRITE: send 0x01 then bytes 0x0A,0x00×15 -> cp_din=128'h0A, one cp_din_valid pulse 1 cycle after the 16th byte, busy high for exactly GAP_CYCLES+1 cycles.
- WRITE, then READ with select 0x02, tx_ready always 1:
  - cp_sel=3'b010 the cycle after the select byte.
  - First tx_valid arrives SETTLE_CYCLES cycles later.
  - 16 bytes go out LSB first and match the cp_dout value modelled at capture.
- TX backpressure: tx_ready toggles 1-of-3 during READ -> no byte lost or duplicated, tx_data stable while stalled, exactly 16 handshakes.
- Errors:
  - Opcode 0x7F -> err_count=1.
  - WRITE with only 5 payload bytes, then silence -> after TIMEOUT_CYCLES (use 100 in the bench) err_count=2, no cp_din_valid, state IDLE.
  - A byte sent during GAP -> err_count=3.
- RESET: send 0x03 -> cp_rst high exactly RST_CYCLES cycles; a mid-TX rst drops tx_valid the next cycle.
